tug_scorer: RTL and testbench



---
 rtl/tug_scorer_if.sv | 27 ++
 rtl/tug_scorer.sv | 167 ++++++++++++++++
 tb/tb_tug_scorer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tug_scorer_if.sv
// Signal bundle between the round/push-detect logic and the tug-of-war scorer.
// The master side drives the round results; the slave side (the scorer) drives the display and match status.
interface tug_scorer_if #(
  parameter int DEPTH = 3
);
  logic               winrnd;
  logic               right;
  logic               leds_on;
  logic               new_match;
  logic [2*DEPTH:0]   score;
  logic [3:0]         wins_l;
  logic [3:0]         wins_r;
  logic               game_over;
  logic               match_over;
  logic               match_winner_right;
  logic               error;

  modport master (
    output winrnd, right, leds_on, new_match,
    input  score, wins_l, wins_r, game_over, match_over, match_winner_right, error
  );

  modport slave (
    input  winrnd, right, leds_on, new_match,
    output score, wins_l, wins_r, game_over, match_over, match_winner_right, error
  );
endinterface

// File: rtl/tug_scorer.sv
// Tug-of-war scorer with match play: marker position, game-win hold, per-side game counters.
// Optional feature macro: FAVOUR_LOSER_EN (two-step recovery from either edge position on a proper push).
module tug_scorer #(
  parameter int DEPTH        = 3,
  parameter int HOLD_CYCLES  = 8,
  parameter int GAMES_TO_WIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  tug_scorer_if.slave  bus
);

  localparam int SW  = 2 * DEPTH + 1;
  localparam int PW  = 6;
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  localparam logic signed [PW-1:0] POS_WIN   = PW'(DEPTH + 1);
  localparam logic signed [PW-1:0] POS_NWIN  = -POS_WIN;
  localparam logic signed [PW-1:0] POS_EDGE  = PW'(DEPTH);
  localparam logic signed [PW-1:0] POS_NEDGE = -POS_EDGE;
  localparam logic signed [PW-1:0] POS_ONE   = PW'(1);
  localparam logic signed [PW-1:0] POS_MONE  = -POS_ONE;
  localparam logic signed [PW-1:0] POS_TWO   = PW'(2);
  localparam logic signed [PW-1:0] POS_MTWO  = -POS_TWO;
  localparam logic [HCW-1:0]       HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [3:0]           GTW       = 4'(GAMES_TO_WIN);

  typedef enum logic [1:0] {S_PLAY, S_HOLD, S_DONE, S_ERR} state_t;

  state_t                 state_q, state_d;
  logic signed [PW-1:0]   pos_q, pos_d;
  logic [HCW-1:0]         hold_q, hold_d;
  logic [3:0]             wins_l_q, wins_l_d;
  logic [3:0]             wins_r_q, wins_r_d;
  logic                   game_over_q, game_over_d;

  logic                   mr_s;
  logic                   pos_oor_s;
  logic                   right_win_s;
  logic                   error_s;
  logic signed [PW-1:0]   step_s;
  logic signed [PW-1:0]   pos_nxt_s;
  logic [SW-1:0]          score_s;

  // A jump-the-light moves the marker against whoever jumped.
  assign mr_s        = (bus.right & bus.leds_on) | (~bus.right & ~bus.leds_on);
  assign pos_oor_s   = (pos_q > POS_WIN) || (pos_q < POS_NWIN);
  assign right_win_s = ~pos_q[PW-1];
  assign error_s     = (state_q == S_ERR) || pos_oor_s;

  // State, position, hold counter, game counters and game_over pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLAY;
      pos_q       <= '0;
      hold_q      <= '0;
      wins_l_q    <= 4'd0;
      wins_r_q    <= 4'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      hold_q      <= hold_d;
      wins_l_q    <= wins_l_d;
      wins_r_q    <= wins_r_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic for the play/hold/done/error controller
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    hold_d      = hold_q;
    wins_l_d    = wins_l_q;
    wins_r_d    = wins_r_q;
    game_over_d = 1'b0;
`ifdef FAVOUR_LOSER_EN
    if (bus.leds_on && mr_s && (pos_q == POS_NEDGE)) begin
      step_s = POS_TWO;
    end else if (bus.leds_on && !mr_s && (pos_q == POS_EDGE)) begin
      step_s = POS_MTWO;
    end else begin
      step_s = mr_s ? POS_ONE : POS_MONE;
    end
`else
    step_s = mr_s ? POS_ONE : POS_MONE;
`endif
    pos_nxt_s = pos_q + step_s;

    if (bus.new_match) begin
      state_d  = S_PLAY;
      pos_d    = '0;
      hold_d   = '0;
      wins_l_d = 4'd0;
      wins_r_d = 4'd0;
    end else if (pos_oor_s) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (bus.winrnd) begin
            pos_d = pos_nxt_s;
            if ((pos_nxt_s == POS_WIN) || (pos_nxt_s == POS_NWIN)) begin
              state_d     = S_HOLD;
              hold_d      = '0;
              game_over_d = 1'b1;
            end else begin
              state_d = S_PLAY;
            end
          end else begin
            state_d = S_PLAY;
          end
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (right_win_s) begin
              wins_r_d = wins_r_q + 4'd1;
            end else begin
              wins_l_d = wins_l_q + 4'd1;
            end
            // Position is kept on match end so the final win pattern stays displayed.
            if ((wins_r_d == GTW) || (wins_l_d == GTW)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_PLAY;
              pos_d   = '0;
            end
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_ERR;
      endcase
    end
  end

  // Score LED decode from the registered state and position
  always_comb begin
    score_s = '0;
    if (error_s) begin
      for (int i = 0; i < SW; i++) score_s[i] = ~i[0];
    end else begin
      case (state_q)
        S_PLAY: begin
          for (int i = 0; i < SW; i++) score_s[i] = (pos_q == PW'(DEPTH - i));
        end
        S_HOLD, S_DONE: begin
          for (int i = 0; i < SW; i++) score_s[i] = right_win_s ? (i < DEPTH) : (i > DEPTH);
        end
        default: score_s = '0;
      endcase
    end
  end

  assign bus.score              = score_s;
  assign bus.wins_l             = wins_l_q;
  assign bus.wins_r             = wins_r_q;
  assign bus.game_over          = game_over_q;
  assign bus.match_over         = (state_q == S_DONE) && !error_s;
  assign bus.match_winner_right = (state_q == S_DONE) && !error_s && right_win_s;
  assign bus.error              = error_s;

endmodule

// File: tb/tb_tug_scorer.sv
// Self-checking bench for tug_scorer (DEPTH=3, HOLD_CYCLES=4, GAMES_TO_WIN=2): directed scenarios then random play
// against a game-level reference model.
module tb_tug_scorer;

  localparam int D   = 3;
  localparam int HC  = 4;
  localparam int GTW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tug_scorer_if #(.DEPTH(D)) tif();

  tug_scorer #(.DEPTH(D), .HOLD_CYCLES(HC), .GAMES_TO_WIN(GTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: marker position, remaining hold cycles, games won, match decided.
  int m_pos, m_hold, m_wl, m_wr, m_go;
  bit m_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_score();
    if (m_hold > 0 || m_done) return (m_pos > 0) ? 7 : 112;
    return 1 << (D - m_pos);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_hold = 0; m_wl = 0; m_wr = 0; m_go = 0; m_done = 1'b0;
  endtask

  task automatic model_edge(input bit w, input bit r, input bit l, input bit nm);
    int stp;
    bit mr;
    m_go = 0;
    if (nm) begin
      model_reset();
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        if (m_pos > 0) m_wr++; else m_wl++;
        if (m_wr == GTW || m_wl == GTW) m_done = 1'b1;
        else m_pos = 0;
      end
    end else if (!m_done && w) begin
      mr  = (r == l);
      stp = mr ? 1 : -1;
`ifdef FAVOUR_LOSER_EN
      if (l && mr && m_pos == -D) stp = 2;
      if (l && !mr && m_pos == D) stp = -2;
`endif
      m_pos += stp;
      if (m_pos == D + 1 || m_pos == -(D + 1)) begin
        m_hold = HC;
        m_go   = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".score"},  32'(tif.score),              32'(exp_score()));
    check_val({tag, ".wins_l"}, 32'(tif.wins_l),             32'(m_wl));
    check_val({tag, ".wins_r"}, 32'(tif.wins_r),             32'(m_wr));
    check_val({tag, ".go"},     32'(tif.game_over),          32'(m_go));
    check_val({tag, ".mover"},  32'(tif.match_over),         32'(m_done));
    check_val({tag, ".mwr"},    32'(tif.match_winner_right), 32'(m_done && m_pos > 0));
    check_val({tag, ".err"},    32'(tif.error),              32'd0);
  endtask

  task automatic step(input string tag, input bit w, input bit r, input bit l, input bit nm);
    tif.winrnd = w; tif.right = r; tif.leds_on = l; tif.new_match = nm;
    @(posedge clk);
    model_edge(w, r, l, nm);
    @(negedge clk);
    tif.winrnd = 1'b0; tif.new_match = 1'b0;
    check_all(tag);
  endtask

  // Called just after a negedge; pulses rst between clock edges.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all(tag);
    #1 rst = 1'b0;
  endtask

  task automatic right_game(input string tag);
    for (int i = 0; i < 4; i++) step(tag, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < HC; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tif.winrnd = 1'b0; tif.right = 1'b0; tif.leds_on = 1'b0; tif.new_match = 1'b0;
    rst = 1'b1;
    model_reset();
    #3 check_all("reset");
    check_val("reset.score_k", 32'(tif.score), 32'h08);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) step("rpush", 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("rpush.win_k", 32'(tif.score), 32'h07);
    check_val("rpush.go_k", 32'(tif.game_over), 32'd1);
    for (int i = 0; i < HC; i++) step("hold", 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("hold.score_k", 32'(tif.score), 32'h08);
    check_val("hold.wins_r_k", 32'(tif.wins_r), 32'd1);

    step("jump_r", 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("jump_r.k", 32'(tif.score), 32'h10);
    step("jump_l", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("jump_l.k", 32'(tif.score), 32'h08);

    for (int i = 0; i < 3; i++) step("lpush", 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("lpush.k", 32'(tif.score), 32'h40);
    step("edge", 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef FAVOUR_LOSER_EN
    check_val("edge.k", 32'(tif.score), 32'h10);
`else
    check_val("edge.k", 32'(tif.score), 32'h20);
`endif
    step("nm", 1'b0, 1'b0, 1'b0, 1'b1);

    right_game("m1");
    right_game("m2");
    check_val("match.over_k", 32'(tif.match_over), 32'd1);
    check_val("match.mwr_k", 32'(tif.match_winner_right), 32'd1);
    check_val("match.score_k", 32'(tif.score), 32'h07);
    check_val("match.wins_k", 32'(tif.wins_r), 32'd2);
    for (int i = 0; i < 3; i++) step("done", 1'b1, 1'b0, 1'b1, 1'b0);
    step("nm2", 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("nm2.k", 32'(tif.score), 32'h08);

    right_game("g1");
    for (int i = 0; i < 4; i++) step("g2", 1'b1, 1'b1, 1'b1, 1'b0);
    step("g2h", 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset("arst");
    check_val("arst.wins_r_k", 32'(tif.wins_r), 32'd0);
    step("arst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step("mvr", 1'b1, 1'b1, 1'b1, 1'b0);
    step("both", 1'b1, 1'b1, 1'b1, 1'b1);
    check_val("both.k", 32'(tif.score), 32'h08);

    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd",
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 8,
             $urandom_range(0, 59) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
